// File: rtl/pwm_channel_arbiter_if.sv
// pwm_channel_arbiter_if
//   Groups the request, position and frame signals shared between the two
//   encoder position sources, the PWM_Generator and the arbiter.
//   Signals:
//     req_ab, req_cd    : level requests from the AB / CD channels
//     pos_ab, pos_cd    : converted positions (WIDTH bits)
//     frame_done        : one-clk end-of-period pulse from PWM_Generator
//     position_out      : position driven to PWM_Generator
//     sel               : current or last owner (0 = AB, 1 = CD)
//     grant_ab/grant_cd : channel ownership flags
//     valid             : position_out belongs to a granted channel
//     fault             : sticky watchdog fault
//   Modports: master = request/generator side, slave = arbiter.
interface pwm_channel_arbiter_if #(
    parameter int unsigned WIDTH = 10
);
    logic             req_ab;
    logic             req_cd;
    logic [WIDTH-1:0] pos_ab;
    logic [WIDTH-1:0] pos_cd;
    logic             frame_done;
    logic [WIDTH-1:0] position_out;
    logic             sel;
    logic             grant_ab;
    logic             grant_cd;
    logic             valid;
    logic             fault;

    modport master (
        output req_ab, req_cd, pos_ab, pos_cd, frame_done,
        input  position_out, sel, grant_ab, grant_cd, valid, fault
    );

    modport slave (
        input  req_ab, req_cd, pos_ab, pos_cd, frame_done,
        output position_out, sel, grant_ab, grant_cd, valid, fault
    );
endinterface

// File: rtl/pwm_channel_arbiter.sv
// pwm_channel_arbiter
//   Shares one PWM_Generator between the AB and CD position channels.
//   A channel holds the grant for HOLD_FRAMES frames while the other one is
//   requesting, then ownership round-robins. The position handed to the
//   generator only changes on frame boundaries. A watchdog raises a sticky
//   fault if frame_done stops arriving while a channel is granted.
//   Ports:
//     clk   : CLK_PWM domain clock
//     reset : synchronous, active-high reset
//     bus   : pwm_channel_arbiter_if slave modport (requests, positions,
//             frame_done in; position_out, sel, grants, valid, fault out)
module pwm_channel_arbiter #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned HOLD_FRAMES = 4,
    parameter int unsigned TIMEOUT     = 2048
) (
    input  logic                        clk,
    input  logic                        reset,
    pwm_channel_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP,
        S_FAULT
    } state_t;

    localparam logic [7:0]  LP_LAST_FRAME = 8'(HOLD_FRAMES - 1);
    localparam logic [15:0] LP_WD_LAST    = 16'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic             r_sel, w_sel_nxt;
    logic [WIDTH-1:0] r_pos, w_pos_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic [15:0]      r_wd, w_wd_nxt;
    logic             r_grant_ab, r_grant_cd, r_valid, r_fault;

    logic             w_any_req;
    logic             w_pick;
    logic             w_owner_req;
    logic             w_other_req;

    assign w_any_req   = bus.req_ab | bus.req_cd;
    // On contention the channel that did not own last time wins.
    assign w_pick      = (bus.req_ab && bus.req_cd) ? ~r_sel : bus.req_cd;
    assign w_owner_req = r_sel ? bus.req_cd : bus.req_ab;
    assign w_other_req = r_sel ? bus.req_ab : bus.req_cd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b1;
            r_pos      <= '0;
            r_cnt      <= '0;
            r_wd       <= '0;
            r_grant_ab <= 1'b0;
            r_grant_cd <= 1'b0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_pos      <= w_pos_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wd       <= w_wd_nxt;
            r_grant_ab <= (w_state_nxt == S_GRANT) && !w_sel_nxt;
            r_grant_cd <= (w_state_nxt == S_GRANT) &&  w_sel_nxt;
            r_valid    <= (w_state_nxt == S_GRANT);
            r_fault    <= (w_state_nxt == S_FAULT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_pos_nxt   = r_pos;
        w_cnt_nxt   = r_cnt;
        w_wd_nxt    = r_wd;
        case (r_state)
            S_IDLE, S_GAP: begin
                w_cnt_nxt = '0;
                w_wd_nxt  = '0;
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_pick;
                    w_pos_nxt   = w_pick ? bus.pos_cd : bus.pos_ab;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_pos_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (bus.frame_done) begin
                    // frame_done takes priority over a coincident timeout.
                    w_wd_nxt  = '0;
                    w_cnt_nxt = (r_cnt == LP_LAST_FRAME) ? r_cnt : r_cnt + 8'd1;
                    if (!w_owner_req || (w_other_req && r_cnt == LP_LAST_FRAME)) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_pos_nxt = r_sel ? bus.pos_cd : bus.pos_ab;
                    end
                end else if (r_wd == LP_WD_LAST) begin
                    w_state_nxt = S_FAULT;
                    w_pos_nxt   = '0;
                end else begin
                    w_wd_nxt = r_wd + 16'd1;
                end
            end
            S_FAULT: begin
                w_pos_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pos_nxt   = '0;
            end
        endcase
    end

    assign bus.position_out = r_pos;
    assign bus.sel          = r_sel;
    assign bus.grant_ab     = r_grant_ab;
    assign bus.grant_cd     = r_grant_cd;
    assign bus.valid        = r_valid;
    assign bus.fault        = r_fault;
endmodule

// File: tb/tb_pwm_channel_arbiter.sv
// tb_pwm_channel_arbiter
//   Directed scenarios plus randomized traffic for pwm_channel_arbiter,
//   compared against an ownership/frame-count reference model.
module tb_pwm_channel_arbiter;
    localparam int HOLD = 4;
    localparam int TMO  = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pwm_channel_arbiter_if #(.WIDTH(10)) bus_if ();

    pwm_channel_arbiter #(
        .WIDTH(10),
        .HOLD_FRAMES(HOLD),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner -1 = nobody, 0 = AB, 1 = CD; frames and
    // clocks-since-frame are plain unbounded counts.
    int         m_owner;
    logic       m_last;
    logic [9:0] m_pos;
    int         m_frames;
    int         m_since;
    logic       m_fault;
    logic       m_pick, m_mine, m_theirs;

    always_comb begin
        m_pick   = (bus_if.req_ab && bus_if.req_cd) ? ~m_last : bus_if.req_cd;
        m_mine   = (m_owner == 1) ? bus_if.req_cd : bus_if.req_ab;
        m_theirs = (m_owner == 1) ? bus_if.req_ab : bus_if.req_cd;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_owner <= -1; m_last <= 1'b1; m_pos <= '0;
            m_frames <= 0; m_since <= 0; m_fault <= 1'b0;
        end else if (m_fault) begin
            m_pos <= '0;
        end else if (m_owner < 0) begin
            if (bus_if.req_ab || bus_if.req_cd) begin
                m_owner  <= m_pick ? 1 : 0;
                m_last   <= m_pick;
                m_pos    <= m_pick ? bus_if.pos_cd : bus_if.pos_ab;
                m_frames <= 0;
                m_since  <= 0;
            end else begin
                m_pos <= '0;
            end
        end else if (bus_if.frame_done) begin
            m_since  <= 0;
            m_frames <= m_frames + 1;
            if (!m_mine || (m_theirs && m_frames + 1 >= HOLD))
                m_owner <= -1;
            else
                m_pos <= (m_owner == 1) ? bus_if.pos_cd : bus_if.pos_ab;
        end else if (m_since + 1 >= TMO) begin
            m_fault <= 1'b1;
            m_owner <= -1;
            m_pos   <= '0;
        end else begin
            m_since <= m_since + 1;
        end
    end

    wire [14:0] obs = {bus_if.position_out, bus_if.sel, bus_if.grant_ab,
                       bus_if.grant_cd, bus_if.valid, bus_if.fault};
    wire [14:0] mexp = {m_pos, m_last, (m_owner == 0), (m_owner == 1),
                        (m_owner >= 0), m_fault};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        bus_if.frame_done = 1'b1;
        tick();
        bus_if.frame_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.req_ab = 1'b0; bus_if.req_cd = 1'b0;
        bus_if.pos_ab = '0; bus_if.pos_cd = '0; bus_if.frame_done = 1'b0;
        tick(); tick();
        total++;
        if (obs !== {10'd0, 1'b1, 4'b0000}) begin
            bad++; $display("FAIL reset_vals got=%h exp=%h", obs, {10'd0, 1'b1, 4'b0000});
        end
        reset = 1'b0;
        tick();
        total++;
        if (obs !== {10'd0, 1'b1, 4'b0000}) begin
            bad++; $display("FAIL idle_no_req got=%h exp=%h", obs, {10'd0, 1'b1, 4'b0000});
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        bus_if.req_ab = 1'b1; bus_if.pos_ab = 10'd300;
        tick();
        total++;
        if (obs !== {10'd300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL first_grant got=%h exp=%h", obs, {10'd300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        bus_if.pos_ab = 10'd500;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus_if.position_out !== 10'd300) begin
                bad++; $display("FAIL hold_mid_frame got=%0d exp=300", bus_if.position_out);
            end
        end
        pulse_frame();
        total++;
        if (bus_if.position_out !== 10'd500) begin
            bad++; $display("FAIL refresh_after_frame got=%0d exp=500", bus_if.position_out);
        end
        total++;
        if (obs !== mexp) begin
            bad++; $display("FAIL single_model got=%h exp=%h", obs, mexp);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus_if.req_ab = 1'b1; bus_if.req_cd = 1'b1;
        bus_if.pos_ab = 10'd100; bus_if.pos_cd = 10'd700;
        tick();
        total++;
        if (obs !== {10'd100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rr_first_ab got=%h exp=%h", obs, {10'd100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        for (int f = 0; f < HOLD; f++) begin
            for (int c = 0; c < 5; c++) begin
                tick();
                total++;
                if (obs !== mexp) begin
                    bad++; $display("FAIL rr_ab_model got=%h exp=%h", obs, mexp);
                end
            end
            pulse_frame();
        end
        total++;
        if (obs !== {10'd100, 1'b0, 4'b0000}) begin
            bad++; $display("FAIL rr_gap got=%h exp=%h", obs, {10'd100, 1'b0, 4'b0000});
        end
        tick();
        total++;
        if (obs !== {10'd700, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rr_cd got=%h exp=%h", obs, {10'd700, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        for (int f = 0; f < HOLD; f++) begin
            repeat (5) tick();
            pulse_frame();
        end
        total++;
        if (obs !== {10'd700, 1'b1, 4'b0000}) begin
            bad++; $display("FAIL rr_gap2 got=%h exp=%h", obs, {10'd700, 1'b1, 4'b0000});
        end
        tick();
        total++;
        if (obs !== {10'd100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rr_back_ab got=%h exp=%h", obs, {10'd100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_no_contention();
        do_reset();
        bus_if.req_ab = 1'b1; bus_if.req_cd = 1'b0;
        tick();
        for (int f = 0; f < 20; f++) begin
            bus_if.pos_ab = 10'($urandom);
            repeat (3) tick();
            pulse_frame();
            total++;
            if (bus_if.grant_ab !== 1'b1 || bus_if.valid !== 1'b1) begin
                bad++; $display("FAIL hold_no_contention got=%b%b exp=11", bus_if.grant_ab, bus_if.valid);
            end
            total++;
            if (obs !== mexp) begin
                bad++; $display("FAIL no_cont_model got=%h exp=%h", obs, mexp);
            end
        end
    endtask

    task automatic test_drop_mid_frame();
        do_reset();
        bus_if.req_ab = 1'b1; bus_if.req_cd = 1'b1;
        bus_if.pos_ab = 10'd111; bus_if.pos_cd = 10'd333;
        tick();
        repeat (2) tick();
        bus_if.req_ab = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus_if.grant_ab !== 1'b1) begin
                bad++; $display("FAIL drop_still_granted got=%b exp=1", bus_if.grant_ab);
            end
        end
        pulse_frame();
        total++;
        if (obs !== {10'd111, 1'b0, 4'b0000}) begin
            bad++; $display("FAIL drop_gap got=%h exp=%h", obs, {10'd111, 1'b0, 4'b0000});
        end
        tick();
        total++;
        if (obs !== {10'd333, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL drop_to_cd got=%h exp=%h", obs, {10'd333, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        end

        bus_if.req_cd = 1'b0;
        do_reset();
        bus_if.req_ab = 1'b1; bus_if.pos_ab = 10'd222;
        tick();
        bus_if.req_ab = 1'b0;
        repeat (2) tick();
        pulse_frame();
        total++;
        if (obs !== {10'd222, 1'b0, 4'b0000}) begin
            bad++; $display("FAIL drop_gap_idle got=%h exp=%h", obs, {10'd222, 1'b0, 4'b0000});
        end
        tick();
        total++;
        if (obs !== {10'd0, 1'b0, 4'b0000}) begin
            bad++; $display("FAIL drop_idle got=%h exp=%h", obs, {10'd0, 1'b0, 4'b0000});
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        bus_if.req_ab = 1'b1; bus_if.req_cd = 1'b0; bus_if.pos_ab = 10'd55;
        tick();
        repeat (TMO - 1) tick();
        pulse_frame();
        total++;
        if (obs !== {10'd55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL wd_edge_frame got=%h exp=%h", obs, {10'd55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        repeat (TMO - 1) tick();
        total++;
        if (bus_if.fault !== 1'b0 || bus_if.grant_ab !== 1'b1) begin
            bad++; $display("FAIL wd_before_timeout got=%b%b exp=01", bus_if.fault, bus_if.grant_ab);
        end
        tick();
        total++;
        if (obs !== {10'd0, 1'b0, 4'b0001}) begin
            bad++; $display("FAIL wd_fault got=%h exp=%h", obs, {10'd0, 1'b0, 4'b0001});
        end
        pulse_frame();
        tick();
        total++;
        if (obs !== {10'd0, 1'b0, 4'b0001}) begin
            bad++; $display("FAIL wd_sticky got=%h exp=%h", obs, {10'd0, 1'b0, 4'b0001});
        end
        do_reset();
        bus_if.req_ab = 1'b0;
        total++;
        if (obs !== {10'd0, 1'b1, 4'b0000}) begin
            bad++; $display("FAIL wd_reset_clears got=%h exp=%h", obs, {10'd0, 1'b1, 4'b0000});
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus_if.req_ab = 1'b1; bus_if.req_cd = 1'b0; bus_if.pos_ab = 10'd450;
        tick();
        tick();
        total++;
        if (bus_if.position_out !== 10'd450) begin
            bad++; $display("FAIL mid_grant_pos got=%0d exp=450", bus_if.position_out);
        end
        reset = 1'b1;
        tick();
        total++;
        if (obs !== {10'd0, 1'b1, 4'b0000}) begin
            bad++; $display("FAIL mid_grant_reset got=%h exp=%h", obs, {10'd0, 1'b1, 4'b0000});
        end
        reset = 1'b0;
        bus_if.req_cd = 1'b1;
        tick();
        total++;
        if (obs !== {10'd450, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL post_reset_ab got=%h exp=%h", obs, {10'd450, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) bus_if.req_ab = ~bus_if.req_ab;
            if ($urandom_range(0, 7) == 0) bus_if.req_cd = ~bus_if.req_cd;
            bus_if.pos_ab     = 10'($urandom);
            bus_if.pos_cd     = 10'($urandom);
            bus_if.frame_done = ($urandom_range(0, 5) == 0);
            reset = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
            tick();
            total++;
            if (obs !== mexp) begin
                bad++; $display("FAIL rand_model n=%0d got=%h exp=%h", n, obs, mexp);
            end
            total++;
            if ((bus_if.grant_ab && bus_if.grant_cd) ||
                (bus_if.valid !== (bus_if.grant_ab | bus_if.grant_cd))) begin
                bad++; $display("FAIL rand_invariant n=%0d got=%b%b%b exp=exclusive", n,
                                bus_if.grant_ab, bus_if.grant_cd, bus_if.valid);
            end
        end
        bus_if.frame_done = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_no_contention();
        test_drop_mid_frame();
        test_watchdog();
        test_reset_mid_grant();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_channel_arbiter.md
Name: pwm_channel_arbiter

Overview:
- Shares the single PWM_Generator instance between two encoder position sources: AB (from the encoder/Converters path) and CD (second channel).
- Grants the generator to one channel for a fixed number of PWM frames, then round-robins to the other.
- Updates the position fed to the generator only on PWM frame boundaries, so no frame is ever truncated.
- Sits between the Converters outputs and PWM_Generator.Position, clocked on the CLK_PWM domain.

Parameters:
- WIDTH, 10, position bus width; matches Position_AB/Position_CD.
- HOLD_FRAMES, 4, frames a channel keeps the grant while the other channel is requesting; legal range 1..255.
- TIMEOUT, 2048, clocks allowed between frame_done pulses while granted before fault; legal range 2..65535.

Ports:
- clk  in  1  CLK_PWM domain clock.
- reset  in  1  synchronous, active-high reset.
- req_ab  in  1  level; AB channel wants the generator.
- req_cd  in  1  level; CD channel wants the generator.
- pos_ab  in  WIDTH  AB converted position.
- pos_cd  in  WIDTH  CD converted position.
- frame_done  in  1  one-clk pulse from PWM_Generator at end of each PWM period.
- position_out  out  WIDTH  position driven to PWM_Generator.
- sel  out  1  current or last owner: 0 = AB, 1 = CD.
- grant_ab  out  1  AB owns the generator.
- grant_cd  out  1  CD owns the generator.
- valid  out  1  position_out belongs to a granted channel.
- fault  out  1  sticky watchdog fault.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values (all registered):
  - position_out = 0, sel = 1 (so AB wins the first arbitration), grant_ab = grant_cd = 0, valid = 0, fault = 0.
  - Frame counter = 0, watchdog = 0, state = IDLE.
  - Reset asserted mid-grant aborts immediately with the same values.
- States: IDLE, GRANT, GAP, FAULT.
- IDLE:
  - Grants = 0, valid = 0, position_out = 0.
  - If any req is high, next cycle enters GRANT.
  - Owner is the requesting channel; if both request, owner = the channel not equal to sel.
  - On entry: sel <= owner, position_out <= pos_owner sampled in the deciding cycle, grant_owner = 1, valid = 1, frame_cnt = 0, watchdog = 0.
  - Latency from req to grant is 1 clk.
- GRANT:
  - Watchdog increments every clk and clears on frame_done.
  - position_out changes only in the cycle after frame_done and takes pos_owner sampled on the frame_done cycle.
  - On frame_done, frame_cnt increments, and the first matching rule applies:
    1. Owner req low → release.
    2. Other req high and frame_cnt == HOLD_FRAMES-1 → release.
    3. Otherwise stay in GRANT and refresh position_out.
  - If the other channel is idle, the owner keeps the grant indefinitely; frame_cnt saturates at HOLD_FRAMES-1.
  - Owner dropping req mid-frame does not release; the release waits for frame_done.
- Release:
  - Goes to GAP for exactly 1 clk: grants = 0, valid = 0, position_out holds its value, sel unchanged.
  - From GAP, arbitration proceeds exactly as in IDLE (same-cycle decision), so the other channel wins if it is requesting.
  - If no req is high, goes to IDLE and position_out is cleared to 0.
- Watchdog:
  - When the watchdog reaches TIMEOUT-1 with no frame_done, enter FAULT.
  - FAULT: grants = 0, valid = 0, position_out = 0, fault = 1. Only reset leaves FAULT.
  - If frame_done coincides with the timeout cycle, frame_done wins: no fault, watchdog clears.
- Invariants:
  - grant_ab and grant_cd are never high together.
  - valid = grant_ab | grant_cd.
  - Requests and positions are sampled synchronously and not resynchronised here; they must already be in the clk domain.
  - Counter widths: frame_cnt 8 bits, watchdog 16 bits.

Test Plan:
- Reset, then req_ab=1, pos_ab=300 → 1 clk later grant_ab=1, sel=0, position_out=300, valid=1. pos_ab→500 mid-frame keeps position_out at 300 until the clk after frame_done, then 500.
- req_ab=req_cd=1 from reset, HOLD_FRAMES=4, pos_cd=700 → AB holds for 4 frame_done pulses, 1-clk GAP (grants 0), then grant_cd=1, position_out=700. After 4 more frames AB is granted again.
- AB granted, req_cd=0, 20 frame_done pulses → grant_ab stays 1 throughout, never enters GAP.
- AB granted, req_ab drops 3 clks before frame_done with req_cd=1 → grant_ab stays 1 until the frame_done clk, GAP 1 clk, then grant_cd=1. If instead req_cd=0 → IDLE, position_out=0.
- TIMEOUT=16, granted, frame_done withheld → fault=1 and grants 0 at clk 16 after the last frame_done. frame_done exactly on the timeout clk → no fault. Reset clears fault.
- Reset asserted mid-GRANT with position_out=450 → next clk all outputs at reset values. The first arbitration afterwards with both requesting grants AB.
